// File: rtl/div_sequencer_if.sv
// Bundle of request, divider-core and result signals for div_sequencer.
// slave is the sequencer's view; master is the surrounding environment.
interface div_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [15:0] req_b;

  logic [31:0] div_a;
  logic [15:0] div_b;
  logic        div_start;
  logic        div_busy;
  logic        div_ready;
  logic [31:0] div_q;
  logic [15:0] div_r;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_q;
  logic [15:0] res_r;
  logic        res_dz;
  logic        res_err;

  modport slave (
    input  req_valid, req_a, req_b, div_busy, div_ready, div_q, div_r, res_ready,
    output req_ready, div_a, div_b, div_start, res_valid, res_q, res_r, res_dz, res_err
  );

  modport master (
    output req_valid, req_a, req_b, div_busy, div_ready, div_q, div_r, res_ready,
    input  req_ready, div_a, div_b, div_start, res_valid, res_q, res_r, res_dz, res_err
  );
endinterface

// File: rtl/div_sequencer.sv
// Request queue and sequencer for the 32/16 divider core: one operation in flight,
// local divide-by-zero handling and a watchdog that turns a hung core into an error result.
module div_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                     clk,
  input  logic                     clrn,
  div_sequencer_if.slave           bus,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [31:0]   r_memA [DEPTH];
  logic [15:0]   r_memB [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_full;

  logic [1:0]    r_state;
  logic [WW-1:0] r_wdog;
  logic [31:0]   r_divA;
  logic [15:0]   r_divB;
  logic          r_divStart;
  logic          r_resValid;
  logic [31:0]   r_resQ;
  logic [15:0]   r_resR;
  logic          r_resDz;
  logic          r_resErr;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_countNext;
  logic [31:0]   w_headA;
  logic [15:0]   w_headB;

  assign w_push  = bus.req_valid && !r_full;
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0) && !bus.div_busy;
  assign w_headA = r_memA[r_rdPtr];
  assign w_headB = r_memB[r_rdPtr];

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memA[r_wrPtr] <= bus.req_a;
      r_memB[r_wrPtr] <= bus.req_b;
    end
  end

  // Full is registered so req_ready never sees a combinational path from the pop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= w_countNext;
      r_full  <= (w_countNext == DEPTH_C);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_wdog     <= '0;
      r_divA     <= '0;
      r_divB     <= '0;
      r_divStart <= 1'b0;
      r_resValid <= 1'b0;
      r_resQ     <= '0;
      r_resR     <= '0;
      r_resDz    <= 1'b0;
      r_resErr   <= 1'b0;
    end else begin
      r_divStart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_headB == '0) begin
              r_resQ   <= 32'hFFFF_FFFF;
              r_resR   <= w_headA[15:0];
              r_resDz  <= 1'b1;
              r_resErr <= 1'b0;
              r_state  <= S_HOLD;
            end else begin
              r_divA  <= w_headA;
              r_divB  <= w_headB;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_divStart <= 1'b1;
          r_wdog     <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.div_ready) begin
            r_resQ     <= bus.div_q;
            r_resR     <= bus.div_r;
            r_resDz    <= 1'b0;
            r_resErr   <= 1'b0;
            r_resValid <= 1'b1;
            r_state    <= S_HOLD;
          end else if (r_wdog == WDOG_LAST) begin
            r_resQ     <= '0;
            r_resR     <= '0;
            r_resDz    <= 1'b0;
            r_resErr   <= 1'b1;
            r_resValid <= 1'b1;
            r_state    <= S_HOLD;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_HOLD: begin
          // A divide-by-zero result enters HOLD with valid low and is presented one cycle later.
          if (r_resValid && bus.res_ready) begin
            r_resValid <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_resValid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = !r_full;
  assign bus.div_a     = r_divA;
  assign bus.div_b     = r_divB;
  assign bus.div_start = r_divStart;
  assign bus.res_valid = r_resValid;
  assign bus.res_q     = r_resQ;
  assign bus.res_r     = r_resR;
  assign bus.res_dz    = r_resDz;
  assign bus.res_err   = r_resErr;
  assign pending       = r_count;

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Request front-end for the team's 32/16 iterative non-restoring divider core, sitting directly upstream of it and consuming its results. It accepts dividend/divisor requests through a valid/ready queue and issues one start pulse per operation. It waits for the core's ready pulse, captures quotient/remainder and presents them on a valid/ready result port. Divide-by-zero is resolved locally without starting the core, and a watchdog converts a hung core into an error result.

Parameters:
DEPTH, 4, request queue entries; power of 2, at least 2.
TIMEOUT, 40, cycles allowed in WAIT before an error result is produced; must exceed the core's 32-iteration latency.

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  queue can accept; equals !full
req_a  in  32  dividend
req_b  in  16  divisor
div_a  out  32  dividend to core
div_b  out  16  divisor to core
div_start  out  1  one-cycle start pulse to core
div_busy  in  1  core busy
div_ready  in  1  core one-cycle done pulse; q/r valid in that cycle
div_q  in  32  core quotient
div_r  in  16  core remainder
res_valid  out  1  result available
res_ready  in  1  result consumer accepts
res_q  out  32  quotient
res_r  out  16  remainder
res_dz  out  1  result is divide-by-zero
res_err  out  1  result is watchdog timeout
pending  out  $clog2(DEPTH)+1  queued request count

Behaviour:
- Reset (clrn=0, asynchronous): queue emptied; pending=0; FSM=IDLE; div_start=0; div_a=0; div_b=0; res_valid=0; res_q=0; res_r=0; res_dz=0; res_err=0; watchdog=0. req_ready=1 once clrn is high. Reset mid-operation abandons all work with no result. The core shares clrn.
- Queue: FIFO, push on req_valid&&req_ready. req_ready depends only on registered full, with no combinational path from the pop. Simultaneous push and pop when non-empty and non-full: pending unchanged. Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if queue is non-empty and div_busy=0, pop the head.
    - If head b==0: load res_q=32'hFFFFFFFF, res_r=a[15:0], res_dz=1, res_err=0, and go to HOLD. The core is not started.
    - Otherwise: register div_a/div_b from the head and go to ISSUE.
    - If div_busy=1, stay in IDLE.
  - ISSUE: div_start=1 for exactly this cycle; watchdog cleared; go to WAIT.
  - WAIT: div_start=0; watchdog increments each cycle.
    - On div_ready=1: capture res_q=div_q, res_r=div_r, res_dz=0, res_err=0; go to HOLD.
    - Else if watchdog reaches TIMEOUT-1: res_q=0, res_r=0, res_err=1; go to HOLD.
    - div_ready takes priority over timeout in the same cycle.
  - HOLD: res_valid=1; result registers are stable. When res_ready=1, go to IDLE and drop res_valid next cycle.
- div_a/div_b hold their value from ISSUE until the next IDLE pop.
- div_ready outside WAIT is ignored.
- Latency with an empty queue and res_ready=1:
  - Request accepted at edge E0, giving pending=1.
  - Popped at edge E1, entering ISSUE.
  - div_start high in cycle E2..E3.
  - res_valid rises at the edge after div_ready.
  - Divide-by-zero: res_valid rises at edge E2.
- Only one operation is in flight; queued requests are serviced in order. Results are never dropped or reordered.
- Arithmetic: unsigned only. Outputs pass through unmodified from the core except for the dz and err substitutions.

Test Plan:
- Single request a=32'h4c7f228a, b=16'h6a0e, with the core connected and res_ready=1 -> exactly one div_start pulse; res_valid with res_q=32'h0000B8A6, res_r=16'h4D76, res_dz=0, res_err=0.
- Back-to-back: push 32'h4c7f228a/16'h6a0e then 32'h00ffff00/16'h0004 on consecutive cycles -> pending reaches 2; results return in order; second is q=32'h003FFFC0, r=0; exactly two start pulses.
- Divide by zero: a=32'h12345678, b=0 -> no div_start; res_valid 2 cycles after accept with q=32'hFFFFFFFF, r=16'h5678, res_dz=1.
- Backpressure: hold res_ready=0 and push DEPTH+1 requests -> req_ready falls after pending=DEPTH while HOLD persists. Releasing res_ready drains all results in order with none lost.
- Watchdog: replace the core with a stub that never pulses div_ready -> res_err=1, res_q=0, res_r=0 exactly TIMEOUT cycles after ISSUE; the next queued request then proceeds normally.
- Reset mid-operation: assert clrn=0 during WAIT with 2 requests queued -> all outputs immediately take their reset values. After release, a fresh 32'h00000064/16'h0007 request gives q=32'h0000000E, r=16'h0002.
